// File: rtl/instruction_memory_pkg.sv
// Shared types and defaults for the instruction memory and its byte-stream program loader.
package aap_imem_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 1024;
    localparam int unsigned DEFAULT_ADDR_W = 20;
    localparam int unsigned WORD_W         = 16;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2,
        WRITE = 2'd3
    } load_state_e;

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch port and program-load stream of the instruction memory, bundled as one interface.
interface instruction_memory_if #(
    parameter int unsigned ADDR_W = aap_imem_pkg::DEFAULT_ADDR_W
);
    import aap_imem_pkg::*;

    logic [ADDR_W-1:0] instruction_rd1;
    logic [WORD_W-1:0] instruction_rd1_out;
    logic              fetch_valid;
    logic              fetch_fault;

    logic              load_start;
    logic [ADDR_W-1:0] load_address;
    logic              load_valid;
    logic [BYTE_W-1:0] load_byte;
    logic              load_ready;
    logic              load_end;
    logic              loading;
    logic              load_error;

    modport master (
        output instruction_rd1, load_start, load_address, load_valid, load_byte, load_end,
        input  instruction_rd1_out, fetch_valid, fetch_fault, load_ready, loading, load_error
    );

    modport slave (
        input  instruction_rd1, load_start, load_address, load_valid, load_byte, load_end,
        output instruction_rd1_out, fetch_valid, fetch_fault, load_ready, loading, load_error
    );

endinterface

// File: rtl/instruction_memory_ram.sv
// Word store with one synchronous write port and one synchronous read port (read-before-write).
module imem_ram
    import aap_imem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Array is never reset so program contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A disabled read returns zero, so the fetch port needs no output mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory: one-cycle fetch port plus a little-endian byte-stream loader that
// assembles 16-bit words and writes them at an auto-incrementing pointer.
module instruction_memory
    import aap_imem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_memory_if.slave  bus
);

    localparam int unsigned      IDX_W     = $clog2(DEPTH);
    localparam logic [32:0]      DEPTH_EXT = 33'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    load_state_e       state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              loading_q, loading_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              accept_c;
    logic              in_range_c;
    logic              we_c;
    logic              re_c;
    logic [ADDR_W-1:0] fetch_addr;
    logic [WORD_W-1:0] rdata;

    assign fetch_addr = bus.instruction_rd1;
    assign in_range_c = 33'(fetch_addr) < DEPTH_EXT;
    assign accept_c   = bus.load_valid && ready_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Loader transitions; load_start overrides everything, including a same-cycle load_end.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lo_d    = lo_q;
        word_d  = word_q;
        err_d   = err_q;
        if (bus.load_start) begin
            state_d = LOW;
            ptr_d   = IDX_W'(bus.load_address);
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                LOW: begin
                    if (bus.load_end) begin
                        state_d = IDLE;
                    end else if (accept_c) begin
                        lo_d    = bus.load_byte;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (bus.load_end) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (accept_c) begin
                        word_d  = {bus.load_byte, lo_q};
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    ptr_d = ptr_q + IDX_W'(1);
                    if (ptr_q == LAST_IDX) begin
                        err_d = 1'b1;
                    end
                    state_d = bus.load_end ? IDLE : LOW;
                end
            endcase
        end
    end

    // Fetch gating looks at the next state so outputs agree with the registered loading flag.
    always_comb begin
        ready_d   = (state_d == LOW) || (state_d == HIGH);
        loading_d = (state_d != IDLE);
        we_c      = (state_q == WRITE) && !bus.load_start;
        fault_d   = !in_range_c;
        valid_d   = in_range_c && (state_d == IDLE);
        re_c      = valid_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            lo_q      <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            loading_q <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            lo_q      <= lo_d;
            word_q    <= word_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            loading_q <= loading_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clock),
        .rst_n   (reset),
        .we_i    (we_c),
        .waddr_i (ptr_q),
        .wdata_i (word_q),
        .re_i    (re_c),
        .raddr_i (IDX_W'(fetch_addr)),
        .rdata_o (rdata)
    );

    assign bus.instruction_rd1_out = rdata;
    assign bus.fetch_valid         = valid_q;
    assign bus.fetch_fault         = fault_q;
    assign bus.load_ready          = ready_q;
    assign bus.loading             = loading_q;
    assign bus.load_error          = err_q;

endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DEPTH, default 1024, instruction storage size in 16-bit words (power of two, 2..2^20) SHALL be provided.
REQ-002 Parameter ADDR_W, default 20, fetch/load address width, SHALL be provided.
REQ-003 clock  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 instruction_rd1  in  ADDR_W  word address driven by the fetch stage.
REQ-006 instruction_rd1_out  out  16  instruction word returned to fetch.
REQ-007 fetch_valid  out  1  instruction_rd1_out holds valid data for the address sampled on the previous edge.
REQ-008 fetch_fault  out  1  previous sampled address was >= DEPTH.
REQ-009 load_start  in  1  one-cycle pulse; begins a program load at load_address.
REQ-010 load_address  in  ADDR_W  first word address of the load.
REQ-011 load_valid  in  1  load_byte is presented.
REQ-012 load_byte  in  8  program byte stream.
REQ-013 load_ready  out  1  block accepts load_byte this cycle.
REQ-014 load_end  in  1  one-cycle pulse; terminates the load.
REQ-015 loading  out  1  loader is not in IDLE.
REQ-016 load_error  out  1  sticky; set by a partial word or wrap; cleared by load_start or reset.

Function
REQ-017 The read path SHALL have one-cycle latency: instruction_rd1_out = mem[instruction_rd1] sampled on the prior edge.
REQ-018 An address >= DEPTH SHALL return 16'h0000 with fetch_fault=1 and fetch_valid=0 for that response cycle.
REQ-019 While loading=1, fetch_valid SHALL be 0 and instruction_rd1_out SHALL read 16'h0000.
REQ-020 Loader FSM states: IDLE, LOW, HIGH, WRITE.
REQ-021 IDLE->LOW on load_start; load pointer <= load_address modulo DEPTH; load_error <= 0.
REQ-022 In LOW, a byte is accepted when load_valid && load_ready; it is held as bits [7:0]; next state HIGH.
REQ-023 In HIGH, an accepted byte forms bits [15:8]; next state WRITE (little-endian, low byte first).
REQ-024 In WRITE, the word SHALL be written to mem[pointer]; load_ready=0; pointer increments; next state LOW.
REQ-025 load_ready SHALL be 1 only in LOW and HIGH.
REQ-026 Pointer at DEPTH-1 SHALL wrap to 0 after a write and set load_error.
REQ-027 load_end in LOW or WRITE SHALL return to IDLE after any pending WRITE completes.
REQ-028 load_end in HIGH SHALL discard the low byte, set load_error, and go to IDLE.
REQ-029 load_start in any non-IDLE state SHALL restart at LOW with the new load_address; any partial word is discarded without error.
REQ-030 load_start and load_end in the same cycle: load_start SHALL win.
REQ-031 A byte arriving with load_end in the same cycle in LOW/HIGH SHALL be ignored.
REQ-032 A read and a write to the same address in one cycle SHALL return the old data.

Reset
REQ-033 On reset=0, asynchronously: FSM=IDLE, pointer=0, instruction_rd1_out=0, fetch_valid=0, fetch_fault=0, load_ready=0, loading=0, load_error=0.
REQ-034 Memory contents SHALL NOT be cleared by reset; reset mid-load abandons the partial word.
REQ-035 The first response after reset release SHALL appear one edge after the first sampled address.

Structure
REQ-036 Package aap_imem_pkg SHALL hold the loader state enum, the default DEPTH, ADDR_W, and the 16-bit word width constant.
REQ-037 Storage SHALL be a sub-module imem_ram: one synchronous write port, one synchronous read port, read-before-write.

Verification
REQ-038 Load at 0x00010 the bytes 34,12,78,56 then load_end; fetch 0x00010,0x00011 -> responses 16'h1234, 16'h5678, fetch_valid=1.
REQ-039 Fetch 0x00400 with DEPTH=1024 -> instruction_rd1_out=0, fetch_fault=1, fetch_valid=0.
REQ-040 Load at 0x003FF with 4 bytes -> words at 0x3FF and 0x000, load_error=1.
REQ-041 Send 3 bytes then load_end -> two bytes are stored as one word, the third is discarded, load_error=1, FSM=IDLE.
REQ-042 Pull reset low during HIGH -> all outputs 0 immediately; previously written words are still readable after release.
REQ-043 Issue load_start and load_end in the same cycle while in HIGH -> FSM=LOW, pointer=new load_address, load_error=0.
